// File: rtl/godmode_pkg.sv
// Shared types and helpers for the GodMode sequencer: state encoding, frame counter width
// and a saturating adder used when stacked pickups extend the god period.
package godmode_pkg;

    localparam int FRAME_CNT_W = 10;

    typedef enum logic [1:0] {IDLE, ACTIVE, WARN, COOLDOWN} god_state_t;

    typedef logic [FRAME_CNT_W-1:0] frame_cnt_t;

    // One extra bit on the sum keeps the overflow visible before clamping.
    function automatic frame_cnt_t sat_add(input frame_cnt_t a, input frame_cnt_t b,
                                           input frame_cnt_t lim);
        logic [FRAME_CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, lim}) ? lim : sum[FRAME_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/godmode_ctrl_frame_countdown.sv
// Loadable frame down-counter that saturates at zero; one instance each for the god
// period, the blink half-period and the cooldown.
module frame_countdown
    import godmode_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  frame_cnt_t load_val,
    input  logic       dec,
    output frame_cnt_t count,
    output logic       zero
);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - frame_cnt_t'(1);
        end
    end

    // Flags that this cycle's decrement lands on (or holds at) zero.
    assign zero = dec && (count <= frame_cnt_t'(1));

endmodule

// File: rtl/godmode_ctrl.sv
// GodMode sequencer: pickup starts a timed invulnerability period whose final frames blink
// the sprite, followed by a pickup cooldown. Define GODMODE_STACK_EN to accumulate pickups.
module godmode_ctrl
    import godmode_pkg::*;
#(
    parameter int DURATION        = 300,
    parameter int WARN_FRAMES     = 60,
    parameter int BLINK_FRAMES    = 6,
    parameter int COOLDOWN_FRAMES = 120,
    parameter int MAX_FRAMES      = 1023
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   startOfFrame,
    input  logic                   powerupTaken,
    input  logic                   gameOver,
    output logic                   GodMode,
    output logic                   godActive,
    output logic [FRAME_CNT_W-1:0] framesLeft,
    output logic                   godExpired
);

    localparam frame_cnt_t MAX_V   = frame_cnt_t'(MAX_FRAMES);
    localparam frame_cnt_t DUR_V   = frame_cnt_t'(DURATION);
    localparam frame_cnt_t LOAD_V  = (DUR_V > MAX_V) ? MAX_V : DUR_V;
    localparam frame_cnt_t WARN_V  = frame_cnt_t'(WARN_FRAMES);
    localparam frame_cnt_t BLINK_V = frame_cnt_t'(BLINK_FRAMES);
    localparam frame_cnt_t COOL_V  = frame_cnt_t'(COOLDOWN_FRAMES);

    god_state_t state;

    logic       pick, tick, in_god, start, retrig, god_tick, to_warn;
    logic       fr_load, fr_dec, fr_zero;
    logic       bl_load, bl_dec, bl_zero;
    logic       cd_load, cd_dec, cd_zero;
    frame_cnt_t fr_val, bl_val, cd_val, bl_count, cd_count;
    frame_cnt_t retrig_val;
    logic       retrig_warn;
    logic       unused_counts;

`ifdef GODMODE_STACK_EN
    assign retrig_val  = sat_add(framesLeft, LOAD_V, MAX_V);
    assign retrig_warn = (retrig_val <= WARN_V);
`else
    assign retrig_val  = LOAD_V;
    assign retrig_warn = 1'b0;
`endif

    // gameOver masks pickups and frame ticks so it wins over both.
    assign pick     = powerupTaken && !gameOver;
    assign tick     = startOfFrame && !gameOver;
    assign in_god   = (state == ACTIVE) || (state == WARN);
    assign start    = (state == IDLE) && pick;
    assign retrig   = in_god && pick;
    assign god_tick = in_god && tick && !pick;
    assign to_warn  = (state == ACTIVE) && god_tick && !fr_zero && (framesLeft == WARN_V + frame_cnt_t'(1));

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        fr_load = gameOver || start || retrig;
        fr_val  = '0;
        fr_dec  = god_tick;
        bl_load = 1'b0;
        bl_val  = '0;
        bl_dec  = (state == WARN) && god_tick;
        cd_load = gameOver || fr_zero;
        cd_val  = gameOver ? '0 : COOL_V;
        cd_dec  = (state == COOLDOWN) && tick;

        if (start)       fr_val = LOAD_V;
        else if (retrig) fr_val = retrig_val;

        if (gameOver || start || fr_zero || (retrig && !retrig_warn)) begin
            bl_load = 1'b1;
        end else if (to_warn || (bl_zero && !fr_zero) || (retrig && retrig_warn)) begin
            bl_load = 1'b1;
            bl_val  = BLINK_V;
        end
    end

    frame_countdown u_frames (
        .clk(clk), .reset(reset), .load(fr_load), .load_val(fr_val), .dec(fr_dec),
        .count(framesLeft), .zero(fr_zero)
    );

    frame_countdown u_blink (
        .clk(clk), .reset(reset), .load(bl_load), .load_val(bl_val), .dec(bl_dec),
        .count(bl_count), .zero(bl_zero)
    );

    frame_countdown u_cooldown (
        .clk(clk), .reset(reset), .load(cd_load), .load_val(cd_val), .dec(cd_dec),
        .count(cd_count), .zero(cd_zero)
    );

    assign unused_counts = ^{bl_count, cd_count};

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            GodMode    <= 1'b0;
            godActive  <= 1'b0;
            godExpired <= 1'b0;
        end else begin
            godExpired <= 1'b0;
            if (gameOver) begin
                state     <= IDLE;
                GodMode   <= 1'b0;
                godActive <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (pick) begin
                            state     <= ACTIVE;
                            GodMode   <= 1'b1;
                            godActive <= 1'b1;
                        end
                    end
                    ACTIVE, WARN: begin
                        if (retrig) begin
                            state   <= retrig_warn ? WARN : ACTIVE;
                            GodMode <= 1'b1;
                        end else if (fr_zero) begin
                            state      <= (COOLDOWN_FRAMES == 0) ? IDLE : COOLDOWN;
                            GodMode    <= 1'b0;
                            godActive  <= 1'b0;
                            godExpired <= 1'b1;
                        end else if (to_warn) begin
                            state <= WARN;
                        end else if (bl_zero) begin
                            GodMode <= ~GodMode;
                        end
                    end
                    COOLDOWN: begin
                        if (cd_zero) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_godmode_ctrl.sv
// Directed bench for godmode_ctrl with a frame-level reference model compared every cycle.
module tb_godmode_ctrl;

    localparam int D = 8, W = 4, B = 1, C = 2, M = 20;
`ifdef GODMODE_STACK_EN
    localparam bit STACK = 1'b1;
`else
    localparam bit STACK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       startOfFrame = 1'b0, powerupTaken = 1'b0, gameOver = 1'b0;
    logic       GodMode, godActive, godExpired;
    logic [9:0] framesLeft;

    int n_checks = 0;
    int n_err    = 0;
    bit run      = 1'b0;

    godmode_ctrl #(
        .DURATION(D), .WARN_FRAMES(W), .BLINK_FRAMES(B), .COOLDOWN_FRAMES(C), .MAX_FRAMES(M)
    ) dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .powerupTaken(powerupTaken),
        .gameOver(gameOver), .GodMode(GodMode), .godActive(godActive),
        .framesLeft(framesLeft), .godExpired(godExpired)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: frames of god time left and cooldown frames left, nothing more.
    int   m_left = 0;
    int   m_cool = 0;
    logic m_exp  = 1'b0;

    function automatic logic exp_god(input int left);
        if (left == 0) return 1'b0;
        if (left > W)  return 1'b1;
        return (((W - left) / B) % 2) == 0;
    endfunction

    always @(posedge clk) begin
        m_exp = 1'b0;
        if (reset || gameOver) begin
            m_left = 0;
            m_cool = 0;
        end else if (powerupTaken && m_left > 0) begin
            m_left = STACK ? ((m_left + D > M) ? M : m_left + D) : D;
        end else if (powerupTaken && m_cool == 0) begin
            m_left = D;
        end else if (startOfFrame) begin
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_exp  = 1'b1;
                    m_cool = C;
                end
            end else if (m_cool > 0) begin
                m_cool--;
            end
        end
    end

    always @(negedge clk) begin
        if (run) begin
            check("GodMode",    GodMode,    exp_god(m_left));
            check("godActive",  godActive,  m_left > 0);
            check("framesLeft", framesLeft, m_left);
            check("godExpired", godExpired, m_exp);
        end
    end

    task automatic cyc(input logic s, input logic p, input logic g);
        startOfFrame = s;
        powerupTaken = p;
        gameOver     = g;
        @(posedge clk);
        #1;
        startOfFrame = 1'b0;
        powerupTaken = 1'b0;
        gameOver     = 1'b0;
    endtask

    task automatic frame();
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    int pat_god[8]  = '{1, 1, 1, 1, 0, 1, 0, 0};
    int stack_exp[3];

    initial begin
        // 1: reset held with pulses applied
        reset = 1'b1;
        cyc(1'b1, 1'b1, 1'b0);
        run = 1'b1;
        cyc(1'b1, 1'b1, 1'b0);
        reset = 1'b0;
        check("rst_GodMode", GodMode, 0);
        check("rst_godActive", godActive, 0);
        check("rst_framesLeft", framesLeft, 0);
        check("rst_godExpired", godExpired, 0);
        cyc(1'b1, 1'b0, 1'b0);
        check("idle_sof_framesLeft", framesLeft, 0);

        // 2: full god period
        cyc(1'b0, 1'b1, 1'b0);
        check("pick_framesLeft", framesLeft, 8);
        check("pick_GodMode", GodMode, 1);
        check("pick_godActive", godActive, 1);
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1, 1'b0, 1'b0);
            check("blink_GodMode", GodMode, pat_god[k]);
            check("count_framesLeft", framesLeft, 7 - k);
            check("period_godActive", godActive, (k < 7) ? 1 : 0);
            check("expire_pulse", godExpired, (k == 7) ? 1 : 0);
            cyc(1'b0, 1'b0, 1'b0);
            check("expire_single", godExpired, 0);
        end

        // 3: pickup during cooldown ignored
        cyc(1'b0, 1'b1, 1'b0);
        check("cool_ignore_framesLeft", framesLeft, 0);
        check("cool_ignore_godActive", godActive, 0);
        cyc(1'b1, 1'b1, 1'b0);
        check("cool_sof_pick_framesLeft", framesLeft, 0);
        frame();
        cyc(1'b0, 1'b1, 1'b0);
        check("rearm_framesLeft", framesLeft, 8);

        // 4: retrigger in WARN coincident with a frame tick
        repeat (6) frame();
        check("warn_framesLeft", framesLeft, 2);
        cyc(1'b1, 1'b1, 1'b0);
        check("retrig_framesLeft", framesLeft, STACK ? 10 : 8);
        check("retrig_GodMode", GodMode, 1);
        stack_exp = STACK ? '{18, 20, 20} : '{8, 8, 8};
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b1, 1'b0);
            check("stack_framesLeft", framesLeft, stack_exp[k]);
        end
        cyc(1'b0, 1'b0, 1'b1);
        check("abort_active_godActive", godActive, 0);

        // 5: gameOver mid-period, pickups ignored while held
        cyc(1'b0, 1'b1, 1'b0);
        repeat (3) frame();
        check("pre_abort_framesLeft", framesLeft, 5);
        cyc(1'b0, 1'b1, 1'b1);
        check("abort_framesLeft", framesLeft, 0);
        check("abort_GodMode", GodMode, 0);
        check("abort_godExpired", godExpired, 0);
        cyc(1'b1, 1'b1, 1'b1);
        check("held_godActive", godActive, 0);
        cyc(1'b0, 1'b0, 1'b0);
        check("released_framesLeft", framesLeft, 0);

        // 6: reset mid-WARN, then a clean period
        cyc(1'b0, 1'b1, 1'b0);
        repeat (5) frame();
        check("midwarn_GodMode", GodMode, 0);
        check("midwarn_framesLeft", framesLeft, 3);
        reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        check("rst2_framesLeft", framesLeft, 0);
        check("rst2_godActive", godActive, 0);
        check("rst2_GodMode", GodMode, 0);
        cyc(1'b0, 1'b1, 1'b0);
        repeat (4) frame();
        check("fresh_warn_GodMode", GodMode, 1);
        frame();
        check("fresh_blink_GodMode", GodMode, 0);
        repeat (6) frame();

        run = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
